// File: rtl/alu_exec_seq_pkg.sv
// alu_exec_seq_pkg: shared constants and decode helpers for the RV32 execute stage.
// Provides ALUop codes (including PASSB/ILLEGAL), major opcodes, funct7 classes,
// M-extension funct3 codes, the decode result payload and the decode function.
package alu_exec_seq_pkg;

  // 4-bit ALUop codes
  localparam logic [3:0] ALU_SLT     = 4'b0010;
  localparam logic [3:0] ALU_SLTU    = 4'b0011;
  localparam logic [3:0] ALU_ADD     = 4'b0110;
  localparam logic [3:0] ALU_PASSB   = 4'b0111;
  localparam logic [3:0] ALU_XOR     = 4'b1000;
  localparam logic [3:0] ALU_OR      = 4'b1001;
  localparam logic [3:0] ALU_AND     = 4'b1010;
  localparam logic [3:0] ALU_SLL     = 4'b1011;
  localparam logic [3:0] ALU_SRA     = 4'b1100;
  localparam logic [3:0] ALU_SRL     = 4'b1101;
  localparam logic [3:0] ALU_SUB     = 4'b1110;
  localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;

  // R-type funct7 classes
  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;
  localparam logic [6:0] F7_MEXT = 7'b0000001;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef struct packed {
    logic [3:0] op;
    logic       is_m;
    logic       illegal;
  } dec_t;

  // funct3 to ALUop for OP/OP-IMM; sub_en/sra_en pick the alternate forms
  function automatic logic [3:0] f3_op(input logic [2:0] f3, input logic sub_en,
                                       input logic sra_en);
    case (f3)
      3'b000:  f3_op = sub_en ? ALU_SUB : ALU_ADD;
      3'b001:  f3_op = ALU_SLL;
      3'b010:  f3_op = ALU_SLT;
      3'b011:  f3_op = ALU_SLTU;
      3'b100:  f3_op = ALU_XOR;
      3'b101:  f3_op = sra_en ? ALU_SRA : ALU_SRL;
      3'b110:  f3_op = ALU_OR;
      default: f3_op = ALU_AND;
    endcase
  endfunction

  // Full decode; m_en says whether funct7=0000001 R-type is a legal M op
  function automatic dec_t decode(input logic [6:0] opc, input logic [2:0] f3,
                                  input logic [6:0] f7, input logic m_en);
    dec_t d;
    d = '{op: ALU_ILLEGAL, is_m: 1'b0, illegal: 1'b1};
    case (opc)
      OPC_OP_IMM: d = '{op: f3_op(f3, 1'b0, f7[5]), is_m: 1'b0, illegal: 1'b0};
      OPC_OP: begin
        if (f7 == F7_BASE || f7 == F7_ALT) begin
          d = '{op: f3_op(f3, f7[5], f7[5]), is_m: 1'b0, illegal: 1'b0};
        end else if (f7 == F7_MEXT && m_en) begin
          d = '{op: ALU_ADD, is_m: 1'b1, illegal: 1'b0};
        end
      end
      OPC_LOAD, OPC_STORE, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH:
        d = '{op: ALU_ADD, is_m: 1'b0, illegal: 1'b0};
      OPC_LUI: d = '{op: ALU_PASSB, is_m: 1'b0, illegal: 1'b0};
      default: ;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/alu_exec_seq_muldiv.sv
// alu_exec_muldiv: iterative radix-2 shift-add multiplier / restoring divider.
// Present only when ALU_EXEC_SEQ_MEXT_EN is defined.
// Ports: clk, rst_n (sync, active-low), start (load operands), fn[2:0] (M funct3),
//        a, b (operands), done (final iteration this cycle), res (valid with done).
`ifdef ALU_EXEC_SEQ_MEXT_EN
module alu_exec_muldiv
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      fn,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic            done,
  output logic [XLEN-1:0] res
);

  localparam int unsigned CW = $clog2(XLEN);

  logic            busy_q, neg_q, nega_q, div0_q, ovf_q;
  logic [CW-1:0]   cnt_q;
  logic [2:0]      fn_q;
  logic [XLEN-1:0] hi_q, lo_q, dv_q, a_raw_q;

  logic            a_sgn, b_sgn, neg_a, neg_b;
  logic [XLEN-1:0] a_mag, b_mag, hi_n, lo_n, quot, rem;
  logic [XLEN:0]   sum, trial, diff;
  logic [2*XLEN-1:0] prod;

  // Operand sign handling at start: iterate on magnitudes
  always_comb begin
    a_sgn = (fn == F3_MULH) || (fn == F3_MULHSU) || (fn == F3_DIV) || (fn == F3_REM);
    b_sgn = (fn == F3_MULH) || (fn == F3_DIV) || (fn == F3_REM);
    neg_a = a_sgn & a[XLEN-1];
    neg_b = b_sgn & b[XLEN-1];
    a_mag = neg_a ? -a : a;
    b_mag = neg_b ? -b : b;
  end

  // One iteration step; the last step feeds res directly so the top captures at done
  always_comb begin
    sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, dv_q} : '0);
    trial = {hi_q, lo_q[XLEN-1]};
    diff  = trial - {1'b0, dv_q};
    if (fn_q[2]) begin
      hi_n = diff[XLEN] ? trial[XLEN-1:0] : diff[XLEN-1:0];
      lo_n = {lo_q[XLEN-2:0], ~diff[XLEN]};
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo_q[XLEN-1:1]};
    end
    prod = neg_q ? -{hi_n, lo_n} : {hi_n, lo_n};
    quot = neg_q ? -lo_n : lo_n;
    rem  = nega_q ? -hi_n : hi_n;
    case (fn_q)
      F3_MUL:                      res = prod[XLEN-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res = prod[2*XLEN-1:XLEN];
      F3_DIV, F3_DIVU:             res = div0_q ? '1 : (ovf_q ? a_raw_q : quot);
      default:                     res = div0_q ? a_raw_q : (ovf_q ? '0 : rem);
    endcase
  end

  assign done = busy_q && (cnt_q == CW'(XLEN - 1));

  // Operand load and iteration registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      fn_q    <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dv_q    <= '0;
      a_raw_q <= '0;
      neg_q   <= 1'b0;
      nega_q  <= 1'b0;
      div0_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (start) begin
      busy_q  <= 1'b1;
      cnt_q   <= '0;
      fn_q    <= fn;
      hi_q    <= '0;
      lo_q    <= fn[2] ? a_mag : b_mag;
      dv_q    <= fn[2] ? b_mag : a_mag;
      a_raw_q <= a;
      neg_q   <= neg_a ^ neg_b;
      nega_q  <= neg_a;
      div0_q  <= (b == '0);
      ovf_q   <= ((fn == F3_DIV) || (fn == F3_REM)) &&
                 (a == {1'b1, {(XLEN-1){1'b0}}}) && (b == '1);
    end else if (busy_q) begin
      hi_q  <= hi_n;
      lo_q  <= lo_n;
      cnt_q <= cnt_q + 1'b1;
      if (done) busy_q <= 1'b0;
    end
  end

endmodule
`endif

// File: rtl/alu_exec_seq.sv
// alu_exec_seq: RV32 execute-stage unit. Decodes opcode/funct3/funct7 to the 4-bit
// ALUop, computes single-cycle results into a held output register, and (with the
// ALU_EXEC_SEQ_MEXT_EN macro defined) runs MUL/DIV/REM on alu_exec_muldiv.
// Ports: clk, rst_n (sync, active-low); in_valid/in_ready input handshake with
//        opcode, funct3, funct7, op_a, op_b; out_valid/out_ready output handshake
//        with result, alu_op, illegal (illegal ops return result 0).
module alu_exec_seq
  import alu_exec_seq_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [6:0]      opcode,
  input  logic [2:0]      funct3,
  input  logic [6:0]      funct7,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic [3:0]      alu_op,
  output logic            illegal
);

  localparam int unsigned SHW = $clog2(XLEN);
`ifdef ALU_EXEC_SEQ_MEXT_EN
  localparam logic M_EN = 1'b1;
`else
  localparam logic M_EN = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_HOLD = 2'd2} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] result_q, result_d, alu_res, md_res;
  logic [3:0]      alu_op_q, alu_op_d;
  logic            illegal_q, illegal_d, out_valid_q, out_valid_d;
  logic            accept, md_done;
  logic [SHW-1:0]  shamt;
  dec_t            dec;

  assign in_ready = (state_q == S_IDLE) || ((state_q == S_HOLD) && out_ready);
  assign accept   = in_valid && in_ready;
  assign shamt    = op_b[SHW-1:0];

  // Decode and single-cycle datapath; ILLEGAL falls through to zero
  always_comb begin
    dec = decode(opcode, funct3, funct7, M_EN);
    case (dec.op)
      ALU_ADD:   alu_res = op_a + op_b;
      ALU_SUB:   alu_res = op_a - op_b;
      ALU_SLT:   alu_res = XLEN'($signed(op_a) < $signed(op_b));
      ALU_SLTU:  alu_res = XLEN'(op_a < op_b);
      ALU_XOR:   alu_res = op_a ^ op_b;
      ALU_OR:    alu_res = op_a | op_b;
      ALU_AND:   alu_res = op_a & op_b;
      ALU_SLL:   alu_res = op_a << shamt;
      ALU_SRA:   alu_res = $unsigned($signed(op_a) >>> shamt);
      ALU_SRL:   alu_res = op_a >> shamt;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

`ifdef ALU_EXEC_SEQ_MEXT_EN
  alu_exec_muldiv #(.XLEN(XLEN)) u_muldiv (
    .clk   (clk),
    .rst_n (rst_n),
    .start (accept && dec.is_m),
    .fn    (funct3),
    .a     (op_a),
    .b     (op_b),
    .done  (md_done),
    .res   (md_res)
  );
`else
  assign md_done = 1'b0;
  assign md_res  = '0;
`endif

  // Next state and held-output capture
  always_comb begin
    state_d   = state_q;
    result_d  = result_q;
    alu_op_d  = alu_op_q;
    illegal_d = illegal_q;
    case (state_q)
      S_BUSY: begin
        if (md_done) begin
          state_d   = S_HOLD;
          result_d  = md_res;
          alu_op_d  = ALU_ADD;
          illegal_d = 1'b0;
        end
      end
      S_IDLE, S_HOLD: begin
        if (accept) begin
          if (dec.is_m) begin
            state_d = S_BUSY;
          end else begin
            state_d   = S_HOLD;
            result_d  = alu_res;
            alu_op_d  = dec.op;
            illegal_d = dec.illegal;
          end
        end else if ((state_q == S_HOLD) && out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    out_valid_d = (state_d == S_HOLD);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      result_q    <= '0;
      alu_op_q    <= 4'b0000;
      illegal_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      result_q    <= result_d;
      alu_op_q    <= alu_op_d;
      illegal_q   <= illegal_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign alu_op    = alu_op_q;
  assign illegal   = illegal_q;

endmodule

// File: doc/alu_exec_seq.md
# alu_exec_seq

Parametrised execute-stage unit for the RV32 datapath. It decodes opcode/funct3/funct7 into the team's 4-bit ALUop and computes the result. Single-cycle ops return a registered result one cycle after acceptance. With the M extension compiled in, MUL/DIV/REM run on an iterative unit behind a valid/ready handshake. It sits between operand muxing and the writeback register, and its stall drives the pipeline hazard logic.

## Interface
- XLEN, 32: operand/result width; legal values 32 or 64, both powers of two
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  operation presented
- in_ready  out  1  unit can accept this cycle
- opcode  in  7  instruction[6:0]
- funct3  in  3  instruction[14:12]
- funct7  in  7  instruction[31:25]
- op_a  in  XLEN  first operand (rs1 or PC, already muxed)
- op_b  in  XLEN  second operand (rs2 or immediate, already muxed)
- out_valid  out  1  result held valid
- out_ready  in  1  consumer takes result
- result  out  XLEN  computed value
- alu_op  out  4  decoded ALUop of the held result
- illegal  out  1  held op was undecodable; result is 0

## Operation
- ALUop codes:
  - ADD 0110, SUB 1110, SLT 0010, SLTU 0011
  - XOR 1000, OR 1001, AND 1010
  - SLL 1011, SRA 1100, SRL 1101
  - PASSB 0111 (LUI), ILLEGAL 1111
- Opcode decode:
  - 0010011: by funct3. For funct3=101, funct7[5] selects SRA/SRL. ADDI never decodes to SUB.
  - 0110011, funct7=0000000/0100000: by funct3. funct7[5] selects SUB/ADD and SRA/SRL.
  - 0000011, 0100011, 0010111, 1101111, 1100111: ADD.
  - 0110111: PASSB.
  - 1100011: ADD (branch compare is external).
  - Anything else: ILLEGAL, with illegal=1 and result=0.
- Shift amount = op_b[log2(XLEN)-1:0]. SLT/SLTU produce 0 or 1, zero-extended.
- M ops (0110011, funct7=0000001, macro enabled), funct3 0–7:
  - MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU.
  - alu_op reports ADD for these.
- Divide by zero: quotient = all ones; remainder = op_a.
- Signed overflow (op_a = most-negative, op_b = -1): quotient = op_a; remainder = 0.
- FSM states:
  - IDLE: no result held.
  - BUSY: iterating an M op.
  - HOLD: result held with out_valid=1.
- FSM transitions:
  - IDLE→HOLD on accept of a single-cycle op.
  - IDLE→BUSY on accept of an M op.
  - BUSY→HOLD when the iteration counter reaches XLEN-1.
  - HOLD→IDLE on out_ready with no new accept.
  - HOLD→HOLD on out_ready plus accept of a single-cycle op (back-to-back).
  - HOLD→BUSY on out_ready plus accept of an M op.
- in_ready = (state==IDLE) | (state==HOLD & out_ready). Accept = in_valid & in_ready.
- Inputs are captured at accept. Input changes after accept have no effect.

## Timing
- Reset (rst_n low at a clock edge):
  - state=IDLE, out_valid=0, result=0, alu_op=0000, illegal=0, counter=0.
  - in_ready is 1 in the first cycle after reset release.
- Single-cycle op: accepted at edge N, out_valid=1 from edge N+1.
- M op: accepted at edge N, out_valid=1 from edge N+XLEN+1. in_ready=0 throughout BUSY.
- HOLD persists with result/alu_op/illegal stable until out_ready=1 at an edge.
- Reset during BUSY or HOLD discards the partial or held result. No output appears afterwards.
- in_valid=1 during BUSY is ignored and not captured.

## Configuration
- ALU_EXEC_SEQ_MEXT_EN defined:
  - The iterative mul/div sub-module is instantiated.
  - M ops behave as above.
- Not defined:
  - No mul/div logic is present.
  - funct7=0000001 R-type decodes as ILLEGAL with single-cycle latency.
  - BUSY is unreachable.

## Structure
- Shared constants headers ALUop.vh and Opcode.vh gain PASSB/ILLEGAL codes and the M funct3 codes.
- FSM state encodings are local to this module.
- Sub-module alu_exec_muldiv:
  - Radix-2 shift-add multiplier and restoring divider sharing one XLEN-cycle counter.
  - Sign correction and the zero/overflow special cases are applied on exit.
  - Interface: start, fn[2:0], a, b, done, res.

## Test plan
- Reset, then ADDI with op_a=5, op_b=-3 → out_valid next cycle, result=2, alu_op=0110.
- R-type funct7=0100000 funct3=101, op_a=0x80000000, op_b=4 → result=0xF8000000, alu_op=1100. Same with funct7=0 → 0x08000000, alu_op=1101.
- With MEXT_EN:
  - DIV op_a=-7, op_b=2 → result=-3 at edge N+33, in_ready=0 during BUSY.
  - REM by 0 → result=op_a.
  - DIV 0x80000000/-1 → 0x80000000.
- MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. Hold out_ready=0 for 5 cycles → result stable. Then out_ready=1 with a back-to-back ADD accepted in the same cycle.
- Assert rst_n low at cycle 10 of a MUL → out_valid stays 0 and in_ready=1 after release. Without MEXT_EN, the same MUL encoding → illegal=1, result=0 after 1 cycle.
